// File: rtl/board_move_ctrl.sv
// Chess board register and move sequencer: turns cursor + select/place key edges into
// committed moves, tracks the side to move, and latches game over on king capture.
module board_move_ctrl #(
    parameter logic [2:0] PROMO_TYPE = 3'b101
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         select_i,
    input  logic         place_i,
    input  logic [2:0]   row_num_i,
    input  logic [2:0]   col_num_i,
    input  logic [63:0]  legal_i,
    output logic [319:0] board_o,
    output logic         sel_valid_o,
    output logic [2:0]   sel_row_o,
    output logic [2:0]   sel_col_o,
    output logic         turn_o,
    output logic         move_done_o,
    output logic         illegal_o,
    output logic [4:0]   captured_o,
    output logic         game_over_o,
    output logic [1:0]   state_o
);

    // Handshake: select_i/place_i are levels; a request is a 0->1 transition seen in one
    // cycle, answered by illegal_o (next cycle) or move_done_o (two cycles later).
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HELD   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  board_q [64];
    logic        select_q, place_q;
    logic        sel_valid_q;
    logic [2:0]  sel_row_q, sel_col_q;
    logic [4:0]  piece_q;
    logic [5:0]  dst_q;
    logic        turn_q;
    logic        move_done_q;
    logic        illegal_q;
    logic [4:0]  captured_q;
    logic        game_over_q;

    logic        sel_e, plc_e, req_en;
    logic [5:0]  cur_idx, src_idx;
    logic [4:0]  cur_sq;
    logic        cur_own, at_src, place_ok;
    logic        illegal_d, take_sel, take_dst, drop_sel, commit;
    logic [4:0]  old_dst, new_piece;
    logic        promo;

    function automatic logic [4:0] start_sq(input logic [5:0] idx);
        logic [2:0] r;
        logic [2:0] c;
        logic [2:0] kind;
        r = idx[5:3];
        c = idx[2:0];
        case (c)
            3'd0, 3'd7: kind = 3'b100;
            3'd1, 3'd6: kind = 3'b010;
            3'd2, 3'd5: kind = 3'b011;
            3'd3:       kind = 3'b101;
            default:    kind = 3'b110;
        endcase
        case (r)
            3'd0:    return {kind, 1'b1, 1'b1};
            3'd1:    return 5'b00111;
            3'd6:    return 5'b00101;
            3'd7:    return {kind, 1'b0, 1'b1};
            default: return 5'b00000;
        endcase
    endfunction

    assign sel_e    = select_i & ~select_q;
    assign plc_e    = place_i & ~place_q;
    assign req_en   = ~game_over_q;
    assign cur_idx  = {row_num_i, col_num_i};
    assign src_idx  = {sel_row_q, sel_col_q};
    assign cur_sq   = board_q[cur_idx];
    assign cur_own  = cur_sq[0] & (cur_sq[1] == turn_q);
    assign at_src   = (cur_idx == src_idx);
    assign place_ok = legal_i[cur_idx] & ~at_src;

    assign old_dst  = board_q[dst_q];
    // A pawn landing on the far rank of its own side becomes PROMO_TYPE.
    assign promo    = (piece_q[4:2] == 3'b001) &&
                      ((!piece_q[1] && dst_q[5:3] == 3'd0) || (piece_q[1] && dst_q[5:3] == 3'd7));
    assign new_piece = promo ? {PROMO_TYPE, piece_q[1], 1'b1} : piece_q;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_en && sel_e && cur_own) begin
                    state_d = S_HELD;
                end
            end
            S_HELD: begin
                if (!req_en) begin
                    state_d = S_IDLE;
                end else if (plc_e) begin
                    if (place_ok) begin
                        state_d = S_COMMIT;
                    end
                end else if (sel_e && at_src) begin
                    state_d = S_IDLE;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output / datapath-control logic; in HELD a place edge shadows a same-cycle select
    always_comb begin
        illegal_d = 1'b0;
        take_sel  = 1'b0;
        take_dst  = 1'b0;
        drop_sel  = 1'b0;
        commit    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_en) begin
                    if (sel_e) begin
                        if (cur_own) take_sel = 1'b1;
                        else         illegal_d = 1'b1;
                    end else if (plc_e) begin
                        illegal_d = 1'b1;
                    end
                end
            end
            S_HELD: begin
                if (!req_en) begin
                    drop_sel = 1'b1;
                end else if (plc_e) begin
                    if (place_ok) take_dst = 1'b1;
                    else          illegal_d = 1'b1;
                end else if (sel_e) begin
                    if (at_src)       drop_sel = 1'b1;
                    else if (cur_own) take_sel = 1'b1;
                    else              illegal_d = 1'b1;
                end
            end
            S_COMMIT: commit = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 64; i++) begin
                board_q[i] <= start_sq(6'(i));
            end
            select_q    <= 1'b1;
            place_q     <= 1'b1;
            sel_valid_q <= 1'b0;
            sel_row_q   <= 3'd0;
            sel_col_q   <= 3'd0;
            piece_q     <= 5'd0;
            dst_q       <= 6'd0;
            turn_q      <= 1'b0;
            move_done_q <= 1'b0;
            illegal_q   <= 1'b0;
            captured_q  <= 5'd0;
            game_over_q <= 1'b0;
        end else begin
            select_q    <= select_i;
            place_q     <= place_i;
            illegal_q   <= illegal_d;
            move_done_q <= commit;
            if (take_sel) begin
                sel_valid_q <= 1'b1;
                sel_row_q   <= row_num_i;
                sel_col_q   <= col_num_i;
                piece_q     <= cur_sq;
            end
            if (drop_sel || commit) begin
                sel_valid_q <= 1'b0;
            end
            if (take_dst) begin
                dst_q <= cur_idx;
            end
            if (commit) begin
                board_q[src_idx] <= 5'd0;
                board_q[dst_q]   <= new_piece;
                captured_q       <= old_dst;
                turn_q           <= ~turn_q;
                if (old_dst[4:2] == 3'b110) begin
                    game_over_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        board_o = '0;
        for (int i = 0; i < 64; i++) begin
            board_o[i*5 +: 5] = board_q[i];
        end
    end

    assign sel_valid_o = sel_valid_q;
    assign sel_row_o   = sel_row_q;
    assign sel_col_o   = sel_col_q;
    assign turn_o      = turn_q;
    assign move_done_o = move_done_q;
    assign illegal_o   = illegal_q;
    assign captured_o  = captured_q;
    assign game_over_o = game_over_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_board_move_ctrl.sv
// Bench for board_move_ctrl: key presses through a driver task, per-press outcomes
// checked against a queue of expected results, board squares checked inline.
module tb_board_move_ctrl;

    logic         clk;
    logic         reset;
    logic         select;
    logic         place;
    logic [2:0]   row_num;
    logic [2:0]   col_num;
    logic [63:0]  legal;
    logic [319:0] board;
    logic         sel_valid;
    logic [2:0]   sel_row;
    logic [2:0]   sel_col;
    logic         turn;
    logic         move_done;
    logic         illegal;
    logic [4:0]   captured;
    logic         game_over;
    logic [1:0]   state;

    int total = 0;
    int bad   = 0;
    logic [11:0] exp_q[$];

    board_move_ctrl dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .select_i    (select),
        .place_i     (place),
        .row_num_i   (row_num),
        .col_num_i   (col_num),
        .legal_i     (legal),
        .board_o     (board),
        .sel_valid_o (sel_valid),
        .sel_row_o   (sel_row),
        .sel_col_o   (sel_col),
        .turn_o      (turn),
        .move_done_o (move_done),
        .illegal_o   (illegal),
        .captured_o  (captured),
        .game_over_o (game_over),
        .state_o     (state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] sq(input int r, input int c);
        return board[(r*8+c)*5 +: 5];
    endfunction

    function automatic logic [63:0] bit_at(input int idx);
        logic [63:0] m;
        m = 64'd1 << idx;
        return m;
    endfunction

    // Driver: one key edge, then a 4-cycle window collecting pulses; the scoreboard entry
    // pushed here is popped and compared at the end of the window.
    task automatic drive_key(input string name, input logic s, input logic p,
                             input int r, input int c, input logic [63:0] lg,
                             input int e_ill, input int e_md, input logic [4:0] e_cap,
                             input logic e_go, input logic e_sv, input logic e_turn);
        logic [11:0] got;
        logic [11:0] want;
        int n_ill;
        int n_md;
        n_ill = 0;
        n_md  = 0;
        row_num = 3'(r);
        col_num = 3'(c);
        legal   = lg;
        select  = s;
        place   = p;
        exp_q.push_back({2'(e_ill), 2'(e_md), e_cap, e_go, e_sv, e_turn});
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) begin
                select = 1'b0;
                place  = 1'b0;
            end
            n_ill += int'(illegal);
            n_md  += int'(move_done);
        end
        got  = {2'(n_ill), 2'(n_md), captured, game_over, sel_valid, turn};
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got ill=%0d md=%0d cap=%b go=%b sv=%b turn=%b, want ill=%0d md=%0d cap=%b go=%b sv=%b turn=%b",
                     name, got[11:10], got[9:8], got[7:3], got[2], got[1], got[0],
                     want[11:10], want[9:8], want[7:3], want[2], want[1], want[0]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; select = 1'b1; place = 1'b0;
        row_num = 3'd6; col_num = 3'd4; legal = '0;
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        total++; if (sq(7,4) !== 5'b11001) begin bad++; $display("FAIL rst_wk: got %b want 11001", sq(7,4)); end
        total++; if (sq(0,3) !== 5'b10111) begin bad++; $display("FAIL rst_bq: got %b want 10111", sq(0,3)); end
        total++; if (sq(6,0) !== 5'b00101) begin bad++; $display("FAIL rst_wp: got %b want 00101", sq(6,0)); end
        total++; if (sq(3,3) !== 5'b00000) begin bad++; $display("FAIL rst_empty: got %b want 00000", sq(3,3)); end
        total++; if (sq(0,0) !== 5'b10011) begin bad++; $display("FAIL rst_br: got %b want 10011", sq(0,0)); end
        total++; if (sq(1,5) !== 5'b00111) begin bad++; $display("FAIL rst_bp: got %b want 00111", sq(1,5)); end
        total++; if (sq(7,6) !== 5'b01001) begin bad++; $display("FAIL rst_wn: got %b want 01001", sq(7,6)); end
        total++;
        if ({turn, sel_valid, illegal, move_done, game_over, captured, state} !== 12'd0) begin
            bad++;
            $display("FAIL rst_outs: got turn=%b sv=%b ill=%b md=%b go=%b cap=%b st=%0d want all 0",
                     turn, sel_valid, illegal, move_done, game_over, captured, state);
        end
        select = 1'b0;
        tick();
    endtask

    task automatic test_first_move();
        drive_key("sel_e2", 1, 0, 6, 4, '0, 0, 0, 5'b0, 0, 1, 0);
        drive_key("plc_e4", 0, 1, 4, 4, bit_at(36), 0, 1, 5'b0, 0, 0, 1);
        total++; if (sq(4,4) !== 5'b00101) begin bad++; $display("FAIL mv_dst: got %b want 00101", sq(4,4)); end
        total++; if (sq(6,4) !== 5'b00000) begin bad++; $display("FAIL mv_src: got %b want 00000", sq(6,4)); end
    endtask

    task automatic test_illegal();
        drive_key("sel_enemy", 1, 0, 7, 0, '0, 1, 0, 5'b0, 0, 0, 1);
        drive_key("sel_own", 1, 0, 1, 0, '0, 0, 0, 5'b0, 0, 1, 1);
        drive_key("plc_same", 0, 1, 1, 0, bit_at(8), 1, 0, 5'b0, 0, 1, 1);
        total++; if (state !== 2'd1) begin bad++; $display("FAIL held_state: got %0d want 1", state); end
    endtask

    task automatic test_held_ops();
        drive_key("reselect", 1, 0, 1, 3, '0, 0, 0, 5'b0, 0, 1, 1);
        total++;
        if ({sel_row, sel_col} !== 6'o13) begin
            bad++; $display("FAIL resel_pos: got %0d,%0d want 1,3", sel_row, sel_col);
        end
        drive_key("sel_empty_held", 1, 0, 3, 3, '0, 1, 0, 5'b0, 0, 1, 1);
        drive_key("plc_not_legal", 0, 1, 2, 3, '0, 1, 0, 5'b0, 0, 1, 1);
        total++; if (sq(2,3) !== 5'b00000) begin bad++; $display("FAIL nl_dst: got %b want 00000", sq(2,3)); end
        total++; if (sq(1,3) !== 5'b00111) begin bad++; $display("FAIL nl_src: got %b want 00111", sq(1,3)); end
        drive_key("deselect", 1, 0, 1, 3, '0, 0, 0, 5'b0, 0, 0, 1);
        total++; if (state !== 2'd0) begin bad++; $display("FAIL desel_state: got %0d want 0", state); end
        drive_key("plc_idle", 0, 1, 2, 3, bit_at(19), 1, 0, 5'b0, 0, 0, 1);
    endtask

    task automatic test_promo_and_king();
        drive_key("b_sel_h7", 1, 0, 1, 7, '0, 0, 0, 5'b0, 0, 1, 1);
        drive_key("b_plc_h6", 0, 1, 2, 7, bit_at(23), 0, 1, 5'b0, 0, 0, 0);
        drive_key("w_sel_c2", 1, 0, 6, 2, '0, 0, 0, 5'b0, 0, 1, 0);
        drive_key("w_cap_c7", 0, 1, 1, 2, bit_at(10), 0, 1, 5'b00111, 0, 0, 1);
        drive_key("b_sel_h6", 1, 0, 2, 7, '0, 0, 0, 5'b00111, 0, 1, 1);
        drive_key("b_plc_h5", 0, 1, 3, 7, bit_at(31), 0, 1, 5'b0, 0, 0, 0);
        drive_key("w_sel_c7", 1, 0, 1, 2, '0, 0, 0, 5'b0, 0, 1, 0);
        drive_key("w_promo", 0, 1, 0, 3, bit_at(3), 0, 1, 5'b10111, 0, 0, 1);
        total++; if (sq(0,3) !== 5'b10101) begin bad++; $display("FAIL promo_sq: got %b want 10101", sq(0,3)); end
        total++; if (sq(1,2) !== 5'b00000) begin bad++; $display("FAIL promo_src: got %b want 00000", sq(1,2)); end
        drive_key("b_sel_h5", 1, 0, 3, 7, '0, 0, 0, 5'b10111, 0, 1, 1);
        drive_key("b_plc_h4", 0, 1, 4, 7, bit_at(39), 0, 1, 5'b0, 0, 0, 0);
        drive_key("w_sel_q", 1, 0, 0, 3, '0, 0, 0, 5'b0, 0, 1, 0);
        drive_key("w_cap_king", 0, 1, 0, 4, bit_at(4), 0, 1, 5'b11011, 1, 0, 1);
        total++; if (sq(0,4) !== 5'b10101) begin bad++; $display("FAIL king_sq: got %b want 10101", sq(0,4)); end
        drive_key("go_sel", 1, 0, 1, 1, '0, 0, 0, 5'b11011, 1, 0, 1);
        drive_key("go_plc", 0, 1, 2, 1, bit_at(17), 0, 0, 5'b11011, 1, 0, 1);
        drive_key("go_both", 1, 1, 1, 1, bit_at(17), 0, 0, 5'b11011, 1, 0, 1);
    endtask

    task automatic test_back_to_back();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        total++; if (game_over !== 1'b0) begin bad++; $display("FAIL go_clear: got %b want 0", game_over); end
        total++; if (sq(0,4) !== 5'b11011) begin bad++; $display("FAIL rst2_bk: got %b want 11011", sq(0,4)); end
        drive_key("sel_e2_b", 1, 0, 6, 4, '0, 0, 0, 5'b0, 0, 1, 0);
        drive_key("sel_plc_same_cyc", 1, 1, 4, 4, bit_at(36), 0, 1, 5'b0, 0, 0, 1);
        total++; if (sq(4,4) !== 5'b00101) begin bad++; $display("FAIL simul_dst: got %b want 00101", sq(4,4)); end
        drive_key("b_sel_e7", 1, 0, 1, 4, '0, 0, 0, 5'b0, 0, 1, 1);
        row_num = 3'd3; col_num = 3'd4; legal = bit_at(28); place = 1'b1;
        tick();
        total++; if (state !== 2'd2) begin bad++; $display("FAIL commit_state: got %0d want 2", state); end
        reset = 1'b1; place = 1'b0;
        tick();
        reset = 1'b0;
        total++; if (sq(1,4) !== 5'b00111) begin bad++; $display("FAIL mid_src: got %b want 00111", sq(1,4)); end
        total++; if (sq(3,4) !== 5'b00000) begin bad++; $display("FAIL mid_dst: got %b want 00000", sq(3,4)); end
        total++; if (sq(4,4) !== 5'b00000) begin bad++; $display("FAIL mid_e4: got %b want 00000", sq(4,4)); end
        total++; if (sq(6,4) !== 5'b00101) begin bad++; $display("FAIL mid_e2: got %b want 00101", sq(6,4)); end
        total++;
        if ({turn, sel_valid, move_done, game_over, state} !== 6'd0) begin
            bad++;
            $display("FAIL mid_outs: got turn=%b sv=%b md=%b go=%b st=%0d want all 0",
                     turn, sel_valid, move_done, game_over, state);
        end
        tick();
        total++; if (move_done !== 1'b0) begin bad++; $display("FAIL mid_md: got %b want 0", move_done); end
    endtask

    initial begin
        reset = 1'b1; select = 1'b0; place = 1'b0;
        row_num = 3'd0; col_num = 3'd0; legal = '0;
        test_reset();
        test_first_move();
        test_illegal();
        test_held_ops();
        test_promo_and_king();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
